lbc_decoder: RTL and testbench
==============================

# lbc_decoder

Receive-side counterpart of the (38,32) linear block encoder. Accepts one 38-bit codeword per handshake, computes the 6-bit syndrome, corrects any single-bit error, and serialises the 32 data bits back onto an 8-bit bus, one byte per clock, first byte first. It also reports per-codeword error status and keeps saturating error counters.

## Interface
- CNT_W, 16, width of each error counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cw_valid  in  1  cw holds a codeword.
- cw  in  [38:1]  codeword.
  - Data bytes: B0=cw[38:31], B1=cw[30:23], B2=cw[22:15], B3=cw[14:7].
  - Parity: cw[6:1].
- cw_ready  out  1  block can accept this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- D  out  [8:1]  decoded data byte.
- d_valid  out  1  D valid.
- d_first  out  1  D is B0.
- d_last  out  1  D is B3.
- err_corr  out  1  current codeword had a single-bit error, now corrected; held for all 4 bytes.
- err_uncorr  out  1  current codeword had an uncorrectable syndrome; held for all 4 bytes.
- corr_cnt  out  [CNT_W-1:0]  count of corrected codewords, saturating.
- uncorr_cnt  out  [CNT_W-1:0]  count of uncorrectable codewords, saturating.

## Operation
- Parity equations. Bk{i} is bit i of byte Bk, bit 1 is the LSB.
  - P6 = B0{2,3,5,7} ^ B1{2,4,6,8} ^ B2{1,3,4,6,8} ^ B3{1,2,4,5,7}
  - P5 = B0{1,2,4,5,8} ^ B1{1,2,5,6} ^ B2{2,3,5,6} ^ B3{1,3,4,6,7}
  - P4 = B0{1,2,6,7,8} ^ B1{1,2,7,8} ^ B2{1,2,3,7,8} ^ B3{2,3,4,8}
  - P3 = B0{1,2} ^ B1{3..8} ^ B2{1,2,3} ^ B3{5..8}
  - P2 = B0{1,2} ^ B1{1..8} ^ B2{4..8}
  - P1 = B0{3..8}
- Syndrome S[6:1] = cw[6:1] ^ {P6..P1}, computed combinationally from cw.
- The 32 data columns are the bit patterns implied by the equations above and are all distinct. Examples: B0{1}=011110, B3{1}=110000.
- Syndrome classes:
  - S=0: clean; data passes unchanged.
  - S one-hot: parity-bit error; data unchanged; err_corr=1.
  - S equal to a data column: invert that data bit; err_corr=1.
  - Any other S (25 values): data passes uncorrected; err_uncorr=1.
- FSM has two states, IDLE and SEND, plus a 2-bit byte counter bcnt.
  - IDLE: cw_ready=1. On cw_valid&cw_ready, load the corrected 32 bits and flags into an output register, bump counters, set bcnt=0, go to SEND.
  - SEND: D = byte bcnt (B0..B3), d_valid=1, d_first=(bcnt==0), d_last=(bcnt==3). bcnt increments each cycle.
  - SEND with bcnt==3: cw_ready=1. If a codeword is accepted, reload and stay in SEND with bcnt=0. Otherwise go to IDLE.
- When cw_ready=0, cw and cw_valid are ignored; the source holds them.
- Counters:
  - Increment by 1 on acceptance of a codeword with the matching flag; hold at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
  - cnt_clr does not affect the datapath.
- Reset:
  - Asynchronously forces IDLE, bcnt=0, and all outputs to 0, except cw_ready, which is 1 after reset.
  - A codeword in flight is discarded; no partial bytes after release.

## Timing
- Codeword accepted at edge N. Bytes B0..B3 are driven, registered, in the cycles following edges N, N+1, N+2, N+3.
- Latency is 1 clock from acceptance to B0.
- Sustained throughput is one codeword per 4 clocks: accepting at the bcnt==3 edge gives a gapless byte stream.
- Flags are valid and stable with d_valid for all 4 bytes of their codeword.
- Counters update at the acceptance edge and are visible the following cycle.
- No combinational path from cw to any output; D, flags and counters are all registered.

## Test plan
- Clean word: cw=0x0_4000_001E (B0=0x01, parity 011110) -> D=01,00,00,00; err_corr=0, err_uncorr=0; counters unchanged.
- Data error: cw=0x0_0000_0040 (all-zero word, cw[7] flipped, S=110000) -> D=00,00,00,00; err_corr=1; corr_cnt=1.
- Parity error: cw=0x0_4000_001F (cw[1] flipped, S=000001) -> D=01,00,00,00; err_corr=1.
- Uncorrectable: all-zero word with cw[32] and cw[1] flipped, cw=0x0_8000_0001 (S=111111) -> D=02,00,00,00 passed raw; err_uncorr=1; uncorr_cnt=1.
- Back-to-back: cw_valid held high with a new word at each bcnt==3 edge for 8 words -> 32 consecutive d_valid cycles; d_first every 4th cycle; cw_ready low in the other cycles.
- Reset mid-frame: rst asserted after B1 -> d_valid=0 immediately; cw_ready=1 after release; B2/B3 never appear. Separately, drive counters to saturation with CNT_W=2 -> they hold at 3; cnt_clr -> 0.

Source files
------------

// File: rtl/lbc_decoder.sv
// (38,32) linear block decoder: single-error correction with syndrome decode,
// byte serialisation of the corrected word and saturating error counters.
module lbc_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cw_valid,
  input  logic [38:1]       cw,
  output logic              cw_ready,
  input  logic              cnt_clr,
  output logic [8:1]        D,
  output logic              d_valid,
  output logic              d_first,
  output logic              d_last,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Parity masks over the data vector {B0,B1,B2,B3}, B0 in the top byte.
  localparam logic [31:0] M6 = 32'h56AA_AD5B;
  localparam logic [31:0] M5 = 32'h9B33_366D;
  localparam logic [31:0] M4 = 32'hE3C3_C78E;
  localparam logic [31:0] M3 = 32'h03FC_07F0;
  localparam logic [31:0] M2 = 32'h03FF_F800;
  localparam logic [31:0] M1 = 32'hFC00_0000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [5:0] parity(input logic [31:0] d);
    return {^(d & M6), ^(d & M5), ^(d & M4), ^(d & M3), ^(d & M2), ^(d & M1)};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [31:0]      sh_q, sh_d;
  logic             ec_q, ec_d;
  logic             eu_q, eu_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic [31:0] dat;
  logic [5:0]  syn;
  logic [31:0] fix;
  logic        col_hit;
  logic        one_hot;
  logic        is_corr;
  logic        is_uncorr;
  logic        ready;
  logic        accept;

  assign dat = cw[38:7];
  assign syn = cw[6:1] ^ parity(dat);

  // Each data column is the parity of a one-hot data word; the constant
  // comparisons fold to a 6-bit decoder per data bit.
  always_comb begin
    fix     = '0;
    col_hit = 1'b0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (syn == parity(32'd1 << j)) begin
        fix[j]  = 1'b1;
        col_hit = 1'b1;
      end
    end
    one_hot   = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
    is_corr   = one_hot | col_hit;
    is_uncorr = (syn != 6'd0) && !is_corr;
  end

  assign ready  = (state_q == IDLE) || (bcnt_q == 2'd3);
  assign accept = cw_valid & ready;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    sh_d         = sh_q;
    ec_d         = ec_q;
    eu_d         = eu_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;

    if (state_q == SEND) begin
      bcnt_d = bcnt_q + 2'd1;
      sh_d   = {sh_q[23:0], 8'h00};
      if (bcnt_q == 2'd3) state_d = IDLE;
    end

    // A reload at the last byte overrides the shift and the return to IDLE.
    if (accept) begin
      sh_d    = dat ^ fix;
      ec_d    = is_corr;
      eu_d    = is_uncorr;
      bcnt_d  = 2'd0;
      state_d = SEND;
      if (is_corr && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_ONE;
      if (is_uncorr && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
    end

    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bcnt_q       <= '0;
      sh_q         <= '0;
      ec_q         <= 1'b0;
      eu_q         <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      sh_q         <= sh_d;
      ec_q         <= ec_d;
      eu_q         <= eu_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign cw_ready   = ready;
  assign D          = sh_q[31:24];
  assign d_valid    = (state_q == SEND);
  assign d_first    = (state_q == SEND) && (bcnt_q == 2'd0);
  assign d_last     = (state_q == SEND) && (bcnt_q == 2'd3);
  assign err_corr   = ec_q;
  assign err_uncorr = eu_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_lbc_decoder.sv
// Bench for lbc_decoder: directed words, back-to-back stream, counter
// saturation on a narrow-counter instance, and reset in mid-frame.
module tb_lbc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cw_valid;
  logic [38:1] cw;
  logic        cnt_clr;

  logic        cw_ready, d_valid, d_first, d_last, err_corr, err_uncorr;
  logic [8:1]  D;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        s_cw_ready, s_d_valid, s_d_first, s_d_last, s_err_corr, s_err_uncorr;
  logic [8:1]  s_D;
  logic [1:0]  s_corr_cnt, s_uncorr_cnt;

  always #5 clk = ~clk;

  lbc_decoder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw(cw), .cw_ready(cw_ready),
    .cnt_clr(cnt_clr), .D(D), .d_valid(d_valid), .d_first(d_first), .d_last(d_last),
    .err_corr(err_corr), .err_uncorr(err_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  lbc_decoder #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw(cw), .cw_ready(s_cw_ready),
    .cnt_clr(cnt_clr), .D(s_D), .d_valid(s_d_valid), .d_first(s_d_first), .d_last(s_d_last),
    .err_corr(s_err_corr), .err_uncorr(s_err_uncorr),
    .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
  );

  typedef struct {
    logic [7:0]  d;
    logic        first;
    logic        last;
    logic        ec;
    logic        eu;
    logic [15:0] cc;
    logic [15:0] uc;
    logic [1:0]  scc;
    logic [1:0]  suc;
  } sb_t;

  sb_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_len = 0;
  int          run_max = 0;
  logic [15:0] m_cc = '0, m_uc = '0;
  logic [1:0]  m_scc = '0, m_suc = '0;

  function automatic logic [38:1] enc(input logic [31:0] d);
    logic [8:1] b0, b1, b2, b3;
    logic p6, p5, p4, p3, p2, p1;
    b0 = d[31:24]; b1 = d[23:16]; b2 = d[15:8]; b3 = d[7:0];
    p6 = b0[2]^b0[3]^b0[5]^b0[7] ^ b1[2]^b1[4]^b1[6]^b1[8]
       ^ b2[1]^b2[3]^b2[4]^b2[6]^b2[8] ^ b3[1]^b3[2]^b3[4]^b3[5]^b3[7];
    p5 = b0[1]^b0[2]^b0[4]^b0[5]^b0[8] ^ b1[1]^b1[2]^b1[5]^b1[6]
       ^ b2[2]^b2[3]^b2[5]^b2[6] ^ b3[1]^b3[3]^b3[4]^b3[6]^b3[7];
    p4 = b0[1]^b0[2]^b0[6]^b0[7]^b0[8] ^ b1[1]^b1[2]^b1[7]^b1[8]
       ^ b2[1]^b2[2]^b2[3]^b2[7]^b2[8] ^ b3[2]^b3[3]^b3[4]^b3[8];
    p3 = b0[1]^b0[2] ^ (^b1[8:3]) ^ b2[1]^b2[2]^b2[3] ^ (^b3[8:5]);
    p2 = b0[1]^b0[2] ^ (^b1) ^ (^b2[8:4]);
    p1 = ^b0[8:3];
    return {d, p6, p5, p4, p3, p2, p1};
  endfunction

  task automatic push_word(input logic [31:0] d, input logic ec, input logic eu,
                           input logic clr);
    if (clr) begin
      m_cc = '0; m_uc = '0; m_scc = '0; m_suc = '0;
    end else begin
      if (ec && m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
      if (eu && m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
      if (ec && m_scc != 2'd3)    m_scc = m_scc + 2'd1;
      if (eu && m_suc != 2'd3)    m_suc = m_suc + 2'd1;
    end
    for (int i = 0; i < 4; i++) begin
      sb_t e;
      e.d = d[31-8*i -: 8]; e.first = (i == 0); e.last = (i == 3);
      e.ec = ec; e.eu = eu; e.cc = m_cc; e.uc = m_uc; e.scc = m_scc; e.suc = m_suc;
      sb.push_back(e);
    end
  endtask

  // Present a word, wait (bounded) for ready, push expectations, complete the handshake.
  task automatic send(input logic [38:1] w, input logic [31:0] exp_d, input logic ec,
                      input logic eu, input logic clr, input logic hold);
    int n;
    cw = w; cw_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cw_ready) break;
      n++;
      if (n > 40) begin
        n_cmp++; n_bad++;
        $error("FAIL accept_timeout got cw_ready=0 exp cw_ready=1");
        cw_valid = 1'b0;
        return;
      end
    end
    cnt_clr = clr;
    push_word(exp_d, ec, eu, clr);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    if (!hold) cw_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (d_valid) begin
        run_len++;
        if (run_len > run_max) run_max = run_len;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $error("FAIL unexpected_byte got D=%h with empty scoreboard", D);
        end else begin
          sb_t e;
          e = sb.pop_front();
          n_cmp++;
          assert ({D, d_first, d_last, err_corr, err_uncorr, cw_ready}
                  === {e.d, e.first, e.last, e.ec, e.eu, e.last})
          else begin
            n_bad++;
            $error("FAIL byte got D=%h f=%b l=%b ec=%b eu=%b rdy=%b exp D=%h f=%b l=%b ec=%b eu=%b rdy=%b",
                   D, d_first, d_last, err_corr, err_uncorr, cw_ready,
                   e.d, e.first, e.last, e.ec, e.eu, e.last);
          end
          if (e.first) begin
            n_cmp++;
            assert ({corr_cnt, uncorr_cnt, s_corr_cnt, s_uncorr_cnt}
                    === {e.cc, e.uc, e.scc, e.suc})
            else begin
              n_bad++;
              $error("FAIL counters got %0d/%0d small %0d/%0d exp %0d/%0d small %0d/%0d",
                     corr_cnt, uncorr_cnt, s_corr_cnt, s_uncorr_cnt,
                     e.cc, e.uc, e.scc, e.suc);
            end
          end
        end
      end else begin
        run_len = 0;
        n_cmp++;
        assert ({cw_ready, d_first, d_last} === 3'b100)
        else begin
          n_bad++;
          $error("FAIL idle_ctrl got rdy/first/last=%b%b%b exp 100", cw_ready, d_first, d_last);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [38:1] w;
    int          pos;
    int          n;

    rst = 1'b1; cw = '0; cw_valid = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    assert ({D, d_valid, d_first, d_last, err_corr, err_uncorr, cw_ready, corr_cnt, uncorr_cnt}
            === {8'h00, 5'b00000, 1'b1, 16'h0000, 16'h0000})
    else begin
      n_bad++;
      $error("FAIL reset_state got D=%h v=%b rdy=%b cc=%0d uc=%0d exp D=00 v=0 rdy=1 cc=0 uc=0",
             D, d_valid, cw_ready, corr_cnt, uncorr_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Directed words from the test plan.
    send(38'h0_4000_001E, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;
    send(38'h0_0000_0040, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;
    send(38'h0_4000_001F, 32'h0100_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;
    send(38'h0_8000_0001, 32'h0200_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;

    // Back-to-back stream of 8 words: clean, data error, parity error, uncorrectable.
    run_max = 0;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      w = enc(d);
      case (k % 4)
        0: send(w, d, 1'b0, 1'b0, 1'b0, 1'b1);
        1: begin
          pos = $urandom_range(38, 7);
          w[pos] = ~w[pos];
          send(w, d, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        2: begin
          pos = $urandom_range(6, 1);
          w[pos] = ~w[pos];
          send(w, d, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        default: begin
          w[32] = ~w[32]; w[1] = ~w[1];
          send(w, d ^ 32'h0200_0000, 1'b0, 1'b1, 1'b0, (k != 7));
        end
      endcase
    end
    repeat (6) @(posedge clk); #1;
    n_cmp++;
    assert (run_max === 32)
    else begin
      n_bad++;
      $error("FAIL gapless_run got %0d consecutive d_valid exp 32", run_max);
    end

    // Counter clear coinciding with a corrected word: clear wins.
    d = 32'hA5C3_0F11;
    w = enc(d);
    w[20] = ~w[20];
    send(w, d, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) @(posedge clk); #1;
    send(enc(32'h1234_5678), 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    assert (sb.size() === 0)
    else begin
      n_bad++;
      $error("FAIL drain got %0d pending bytes exp 0", sb.size());
    end
    repeat (2) @(posedge clk); #1;

    // Reset after B1: B2/B3 must never appear.
    d = 32'h1122_3344;
    w = enc(d);
    w[3] = ~w[3];
    send(w, d, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    assert ({d_valid, cw_ready, D, err_corr, err_uncorr, corr_cnt, uncorr_cnt}
            === {1'b0, 1'b1, 8'h00, 2'b00, 16'h0000, 16'h0000})
    else begin
      n_bad++;
      $error("FAIL reset_midframe got v=%b rdy=%b D=%h ec=%b cc=%0d exp v=0 rdy=1 D=00 ec=0 cc=0",
             d_valid, cw_ready, D, err_corr, corr_cnt);
    end
    n_cmp++;
    assert (sb.size() === 2)
    else begin
      n_bad++;
      $error("FAIL reset_pending got %0d pending bytes exp 2", sb.size());
    end
    while (sb.size() != 0) void'(sb.pop_front());
    m_cc = '0; m_uc = '0; m_scc = '0; m_suc = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    n_cmp++;
    assert ({d_valid, cw_ready, s_corr_cnt, s_uncorr_cnt} === {1'b0, 1'b1, 4'b0000})
    else begin
      n_bad++;
      $error("FAIL post_reset got v=%b rdy=%b scc=%0d suc=%0d exp v=0 rdy=1 scc=0 suc=0",
             d_valid, cw_ready, s_corr_cnt, s_uncorr_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
